// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: scans a configured number of valid bits for a
// PAT_W-bit pattern and counts matches, with optional overlap.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting; config writes and start honoured here
  // RUN   | sampling valid bits until bit count reaches stored len
  // DONE  | single-cycle end-of-run, done pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   mcount_q, mcount_d;
  logic               match_q, match_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
      mcount_q <= '0;
      match_q  <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bitcnt_q <= bitcnt_d;
      mcount_q <= mcount_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    bitcnt_d = bitcnt_q;
    mcount_d = mcount_q;
    match_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ovl_d = cfg_overlap;
        end else if (start) begin
          mcount_d = '0;
          if (len_q != '0) begin
            state_d  = RUN;
            hist_d   = '0;
            fill_d   = '0;
            bitcnt_d = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (x_valid) begin
          hist_d   = {hist_q[PAT_W-2:0], x};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
          // Match is judged on the post-shift history and fill
          if (fill_d == FILL_FULL && hist_d == pat_q) begin
            match_d = 1'b1;
            if (mcount_q != CNT_MAX) mcount_d = mcount_q + CNT_W'(1);
            if (!ovl_q) fill_d = '0;
          end
          if (bitcnt_d == len_q) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = mcount_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus random
// streams checked cycle by cycle against a queue-based pattern model.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             start;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             done;

  int n_total = 0;
  int n_pass  = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .x(x),
    .x_valid(x_valid), .busy(busy), .match(match), .match_count(match_count),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one run and checks every cycle against a model that keeps the
  // bits seen since the last history clear and compares the newest PAT_W.
  task automatic run_stream(input logic [PAT_W-1:0] pat, input int len, input bit ovl,
                            input logic [255:0] bits, input int gap_pos, input int gap_n,
                            input bit rand_valid, input bit do_cfg, input int inject,
                            output int final_count, output int cycles);
    bit q[$];
    int sampled = 0;
    int gaps_left = gap_n;
    int exp_cnt = 0;
    bit xv, exp_m, hit;
    cycles = 0;
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len[CNT_W-1:0]; cfg_overlap = ovl;
      start = 1'b1;
      step();
      cfg_we = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    if (len == 0) begin
      n_total++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL len0_done: done=%b busy=%b want 1 1", done, busy); else n_pass++;
      n_total++; if (match_count !== 0) $display("FAIL len0_count: got %0d want 0", match_count); else n_pass++;
      step();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL len0_idle: busy=%b done=%b want 0 0", busy, done); else n_pass++;
      final_count = int'(match_count);
      return;
    end
    n_total++; if (busy !== 1'b1 || done !== 1'b0 || match !== 1'b0 || match_count !== 0)
      $display("FAIL run_start: busy=%b done=%b match=%b cnt=%0d want 1 0 0 0", busy, done, match, match_count);
    else n_pass++;
    while (sampled < len && cycles < len * 4 + 50) begin
      if (sampled == gap_pos && gaps_left > 0) begin xv = 1'b0; gaps_left--; end
      else if (rand_valid) xv = ($urandom_range(0, 2) != 0);
      else xv = 1'b1;
      x_valid = xv;
      x = xv ? bits[sampled] : 1'($urandom_range(0, 1));
      if (sampled == inject && xv) begin
        cfg_we = 1'b1; cfg_pattern = '1; cfg_len = 8'd3; cfg_overlap = ~ovl; start = 1'b1;
      end
      step();
      cfg_we = 1'b0; start = 1'b0;
      cycles++;
      exp_m = 1'b0;
      if (xv) begin
        q.push_back(bits[sampled]);
        sampled++;
        if (q.size() >= PAT_W) begin
          hit = 1'b1;
          for (int k = 0; k < PAT_W; k++)
            if (q[q.size() - 1 - k] != pat[k]) hit = 1'b0;
          if (hit) begin
            exp_m = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
            if (!ovl) q.delete();
          end
        end
      end
      n_total++; if (match !== exp_m) $display("FAIL match@bit%0d: got %b want %b", sampled, match, exp_m); else n_pass++;
      n_total++; if (match_count !== exp_cnt[CNT_W-1:0]) $display("FAIL count@bit%0d: got %0d want %0d", sampled, match_count, exp_cnt); else n_pass++;
      n_total++; if (done !== (xv && sampled == len) || busy !== 1'b1)
        $display("FAIL done@bit%0d: done=%b busy=%b want %b 1", sampled, done, busy, (xv && sampled == len));
      else n_pass++;
    end
    n_total++; if (sampled != len) $display("FAIL run_timeout: sampled %0d want %0d", sampled, len); else n_pass++;
    x_valid = 1'b0;
    step();
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0)
      $display("FAIL run_end_idle: busy=%b done=%b match=%b want 0 0 0", busy, done, match);
    else n_pass++;
    x_valid = 1'b1; x = 1'b1;
    step(); step();
    x_valid = 1'b0;
    n_total++; if (match_count !== exp_cnt[CNT_W-1:0] || busy !== 1'b0)
      $display("FAIL count_hold: got %0d busy=%b want %0d 0", match_count, busy, exp_cnt);
    else n_pass++;
    final_count = int'(match_count);
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_we = 1'b1; cfg_pattern = 4'b1010; cfg_len = 8'd5; cfg_overlap = 1'b1;
    start = 1'b1; x = 1'b1; x_valid = 1'b1;
    step(); step();
    n_total++; if (busy !== 1'b0 || match !== 1'b0 || done !== 1'b0 || match_count !== 0)
      $display("FAIL reset_outputs: busy=%b match=%b done=%b cnt=%0d want 0", busy, match, done, match_count);
    else n_pass++;
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; x_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (done !== 1'b1) $display("FAIL reset_len_zero: done=%b want 1", done); else n_pass++;
    step();
  endtask

  task automatic test_run1();
    logic [255:0] b = '0;
    int c, cy;
    b[0] = 1'b1; b[4] = 1'b1;
    run_stream(4'b1000, 8, 1'b1, b, -1, 0, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 2) $display("FAIL run1_count: got %0d want 2", c); else n_pass++;
    n_total++; if (cy != 8) $display("FAIL run1_cycles: got %0d want 8", cy); else n_pass++;
  endtask

  task automatic test_overlap();
    logic [255:0] b = '0;
    int c, cy;
    b[0] = 1'b1; b[2] = 1'b1; b[4] = 1'b1;
    run_stream(4'b1010, 6, 1'b1, b, -1, 0, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 2) $display("FAIL run2_ovl1: got %0d want 2", c); else n_pass++;
    run_stream(4'b1010, 6, 1'b0, b, -1, 0, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 1) $display("FAIL run2_ovl0: got %0d want 1", c); else n_pass++;
  endtask

  task automatic test_gaps();
    logic [255:0] b = '0;
    int c, cy;
    b[0] = 1'b1; b[4] = 1'b1;
    run_stream(4'b1000, 8, 1'b1, b, 2, 3, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 2) $display("FAIL run3_count: got %0d want 2", c); else n_pass++;
    n_total++; if (cy != 11) $display("FAIL run3_cycles: got %0d want 11", cy); else n_pass++;
  endtask

  task automatic test_len0();
    int c, cy;
    run_stream(4'b0110, 0, 1'b0, '0, -1, 0, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 0) $display("FAIL run4_count: got %0d want 0", c); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [255:0] b = '0;
    int c, cy;
    b[0] = 1'b1; b[4] = 1'b1;
    cfg_we = 1'b1; cfg_pattern = 4'b1000; cfg_len = 8'd8; cfg_overlap = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x_valid = 1'b1; x = b[i];
      step();
    end
    n_total++; if (match_count !== 1) $display("FAIL run5_pre: cnt=%0d want 1", match_count); else n_pass++;
    rst = 1'b0; x = b[5];
    step();
    rst = 1'b1; x_valid = 1'b0;
    n_total++; if (busy !== 1'b0 || match !== 1'b0 || done !== 1'b0 || match_count !== 0)
      $display("FAIL run5_abort: busy=%b match=%b done=%b cnt=%0d want 0", busy, match, done, match_count);
    else n_pass++;
    x_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL run5_nodone: done=%b busy=%b want 0 0", done, busy); else n_pass++;
    end
    x_valid = 1'b0;
    run_stream(4'b1000, 8, 1'b1, b, -1, 0, 1'b0, 1'b1, -1, c, cy);
    n_total++; if (c != 2) $display("FAIL run5_rerun: got %0d want 2", c); else n_pass++;
  endtask

  task automatic test_cfg_in_run();
    logic [255:0] b = '0;
    int c, cy;
    b[0] = 1'b1; b[4] = 1'b1;
    run_stream(4'b1000, 8, 1'b1, b, -1, 0, 1'b0, 1'b1, 2, c, cy);
    n_total++; if (c != 2 || cy != 8) $display("FAIL run6_count: got %0d/%0d want 2/8", c, cy); else n_pass++;
    b = '0;
    for (int i = 0; i < 5; i++) b[i] = 1'b1;
    run_stream(4'b1000, 8, 1'b1, b, -1, 0, 1'b0, 1'b0, -1, c, cy);
    n_total++; if (c != 1) $display("FAIL run6_pattern_kept: got %0d want 1", c); else n_pass++;
  endtask

  task automatic test_random();
    logic [255:0] b;
    int c, cy;
    for (int r = 0; r < 25; r++) begin
      for (int w = 0; w < 8; w++) b[w*32 +: 32] = $urandom;
      run_stream(4'($urandom), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), b,
                 -1, 0, 1'b1, 1'b1, -1, c, cy);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; x = 1'b0; x_valid = 1'b0;
    test_reset();
    test_run1();
    test_overlap();
    test_gaps();
    test_len0();
    test_reset_mid();
    test_cfg_in_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
